// File: rtl/led_fade_ctrl_if.sv
// Control/status bundle between a breathing-LED sequencer and whatever drives it.
// The master side sets enable and range; the slave side returns intensity and step pulses.
interface led_fade_ctrl_if;
  logic       en;
  logic [3:0] min_level;
  logic [3:0] max_level;
  logic [3:0] intensity;
  logic       step_tick;
  logic       cycle_done;

  modport master (
    output en, min_level, max_level,
    input  intensity, step_tick, cycle_done
  );

  modport slave (
    input  en, min_level, max_level,
    output intensity, step_tick, cycle_done
  );
endinterface

// File: rtl/led_fade_ctrl.sv
// Breathing-effect intensity sequencer feeding the 4-bit sigma-delta LED modulator.
// Optional perceptual output table enabled by defining LED_FADE_GAMMA_EN.
//
//   state     | meaning
//   ----------+--------------------------------------------------
//   IDLE      | disabled, level forced to 0
//   RAMP_UP   | level climbs one per step toward max_level
//   HOLD_HIGH | level parked at peak for HOLD_STEPS steps
//   RAMP_DOWN | level falls one per step toward min_level
//   HOLD_LOW  | level parked at floor; also the degenerate-range home
module led_fade_ctrl #(
  parameter int STEP_DIV   = 1000000,
  parameter int HOLD_STEPS = 8
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  led_fade_ctrl_if.slave io_fade
);

  localparam int DIV_W  = $clog2(STEP_DIV);
  localparam int HOLD_W = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(STEP_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_STEPS - 1);

  typedef enum logic [2:0] {
    IDLE,
    RAMP_UP,
    HOLD_HIGH,
    RAMP_DOWN,
    HOLD_LOW
  } state_t;

  state_t            r_state;
  logic [DIV_W-1:0]  r_div_cnt;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [3:0]        r_level;
  logic              r_step_tick;
  logic              r_cycle_done;

  logic [3:0] w_level_inc;
  logic [3:0] w_level_dec;
  logic       w_degenerate;
  logic       w_step;

  // inc/dec are only used when the level is strictly inside the range, so they never wrap
  assign w_level_inc  = r_level + 4'd1;
  assign w_level_dec  = r_level - 4'd1;
  assign w_degenerate = (io_fade.min_level >= io_fade.max_level);
  assign w_step       = (r_div_cnt == DIV_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_div_cnt    <= '0;
      r_hold_cnt   <= '0;
      r_level      <= 4'd0;
      r_step_tick  <= 1'b0;
      r_cycle_done <= 1'b0;
    end else if (!io_fade.en) begin
      r_state      <= IDLE;
      r_div_cnt    <= '0;
      r_hold_cnt   <= '0;
      r_level      <= 4'd0;
      r_step_tick  <= 1'b0;
      r_cycle_done <= 1'b0;
    end else if (r_state == IDLE) begin
      r_state      <= RAMP_UP;
      r_div_cnt    <= '0;
      r_hold_cnt   <= '0;
      r_level      <= io_fade.min_level;
      r_step_tick  <= 1'b0;
      r_cycle_done <= 1'b0;
    end else if (!w_step) begin
      r_div_cnt    <= r_div_cnt + DIV_W'(1);
      r_step_tick  <= 1'b0;
      r_cycle_done <= 1'b0;
    end else begin
      r_div_cnt    <= '0;
      r_step_tick  <= 1'b1;
      r_cycle_done <= 1'b0;
      if (w_degenerate) begin
        r_level    <= io_fade.min_level;
        r_hold_cnt <= '0;
        r_state    <= HOLD_LOW;
      end else begin
        case (r_state)
          RAMP_UP: begin
            if (r_level < io_fade.max_level) begin
              r_level <= w_level_inc;
              if (w_level_inc >= io_fade.max_level) begin
                r_hold_cnt <= '0;
                r_state    <= HOLD_HIGH;
              end
            end else begin
              // peak was lowered below the current level mid-ramp
              r_level    <= io_fade.max_level;
              r_hold_cnt <= '0;
              r_state    <= HOLD_HIGH;
            end
          end
          HOLD_HIGH: begin
            if (r_hold_cnt == HOLD_LAST) begin
              r_hold_cnt <= '0;
              r_state    <= RAMP_DOWN;
            end else begin
              r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
            end
          end
          RAMP_DOWN: begin
            if (r_level > io_fade.min_level) begin
              r_level <= w_level_dec;
              if (w_level_dec <= io_fade.min_level) begin
                r_hold_cnt <= '0;
                r_state    <= HOLD_LOW;
              end
            end else begin
              r_level    <= io_fade.min_level;
              r_hold_cnt <= '0;
              r_state    <= HOLD_LOW;
            end
          end
          HOLD_LOW: begin
            if (r_hold_cnt == HOLD_LAST) begin
              r_hold_cnt   <= '0;
              r_state      <= RAMP_UP;
              r_cycle_done <= 1'b1;
            end else begin
              r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
            end
          end
          default: begin
            r_hold_cnt <= '0;
            r_state    <= IDLE;
          end
        endcase
      end
    end
  end

`ifdef LED_FADE_GAMMA_EN
  function automatic logic [3:0] gamma_lut(input logic [3:0] lvl);
    logic [3:0] g;
    case (lvl)
      4'd0:    g = 4'd0;
      4'd1:    g = 4'd0;
      4'd2:    g = 4'd0;
      4'd3:    g = 4'd1;
      4'd4:    g = 4'd1;
      4'd5:    g = 4'd2;
      4'd6:    g = 4'd2;
      4'd7:    g = 4'd3;
      4'd8:    g = 4'd4;
      4'd9:    g = 4'd5;
      4'd10:   g = 4'd7;
      4'd11:   g = 4'd8;
      4'd12:   g = 4'd10;
      4'd13:   g = 4'd11;
      4'd14:   g = 4'd13;
      default: g = 4'd15;
    endcase
    return g;
  endfunction

  logic [3:0] r_gamma;
  logic       r_step_tick_d;
  logic       r_cycle_done_d;

  // pulses are delayed alongside the table lookup so they line up with the word they mark
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_gamma        <= 4'd0;
      r_step_tick_d  <= 1'b0;
      r_cycle_done_d <= 1'b0;
    end else begin
      r_gamma        <= gamma_lut(r_level);
      r_step_tick_d  <= r_step_tick;
      r_cycle_done_d <= r_cycle_done;
    end
  end

  assign io_fade.intensity  = r_gamma;
  assign io_fade.step_tick  = r_step_tick_d;
  assign io_fade.cycle_done = r_cycle_done_d;
`else
  assign io_fade.intensity  = r_level;
  assign io_fade.step_tick  = r_step_tick;
  assign io_fade.cycle_done = r_cycle_done;
`endif

endmodule

// File: tb/tb_led_fade_ctrl.sv
// Scoreboard bench for led_fade_ctrl: expected steps are queued by the stimulus
// and checked by a monitor each time the DUT raises its step pulse.
module tb_led_fade_ctrl;

  localparam int STEP_DIV   = 4;
  localparam int HOLD_STEPS = 2;
`ifdef LED_FADE_GAMMA_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  led_fade_ctrl_if fade();

  led_fade_ctrl #(
    .STEP_DIV   (STEP_DIV),
    .HOLD_STEPS (HOLD_STEPS)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_fade (fade)
  );

  typedef struct {
    logic [3:0] inten;
    logic       done;
    int         gap;
  } exp_t;

  exp_t q[$];
  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int anchor      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] exp_i(input logic [3:0] lvl);
`ifdef LED_FADE_GAMMA_EN
    logic [3:0] g;
    case (lvl)
      4'd0, 4'd1, 4'd2: g = 4'd0;
      4'd3, 4'd4:       g = 4'd1;
      4'd5, 4'd6:       g = 4'd2;
      4'd7:             g = 4'd3;
      4'd8:             g = 4'd4;
      4'd9:             g = 4'd5;
      4'd10:            g = 4'd7;
      4'd11:            g = 4'd8;
      4'd12:            g = 4'd10;
      4'd13:            g = 4'd11;
      4'd14:            g = 4'd13;
      default:          g = 4'd15;
    endcase
    return g;
`else
    return lvl;
`endif
  endfunction

  task automatic push(input logic [3:0] lvl, input logic done, input int gap);
    exp_t e;
    e.inten = exp_i(lvl);
    e.done  = done;
    e.gap   = gap;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drain();
    int budget;
    budget = STEP_DIV * q.size() + 16;
    while (q.size() != 0 && budget > 0) begin
      @(negedge clk);
      #1;
      budget--;
    end
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout: got %0d steps pending expected 0", q.size());
      q.delete();
    end
  endtask

  // after the EN-sampling edge: mark the step-timing origin and let the output settle
  task automatic start_edge();
    @(posedge clk);
    #1;
    anchor = cyc;
    repeat (LAT) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && fade.cycle_done && !fade.step_tick) begin
      miscompares++;
      $display("FAIL done_without_tick at cycle %0d: got 1 expected 0", cyc);
    end
    if (rst_n && fade.step_tick) begin
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_tick at cycle %0d: got tick int=%0d expected none",
                 cyc, fade.intensity);
      end else begin
        e = q.pop_front();
        vectors++;
        if (fade.intensity !== e.inten || fade.cycle_done !== e.done || (cyc - anchor) != e.gap) begin
          miscompares++;
          $display("FAIL step_vec at cycle %0d: got int=%0d done=%0b gap=%0d expected int=%0d done=%0b gap=%0d",
                   cyc, fade.intensity, fade.cycle_done, cyc - anchor, e.inten, e.done, e.gap);
        end
      end
      anchor = cyc;
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    fade.en        = 1'b0;
    fade.min_level = 4'd2;
    fade.max_level = 4'd5;
    #2;
    chk("reset_intensity", int'(fade.intensity), 0);
    chk("reset_tick", int'(fade.step_tick), 0);
    chk("reset_done", int'(fade.cycle_done), 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;

    // full breathe cycle, MIN=2 MAX=5
    @(negedge clk);
    #1 fade.en = 1'b1;
    start_edge();
    chk("start_level", int'(fade.intensity), int'(exp_i(4'd2)));
    push(4'd3, 1'b0, STEP_DIV + LAT);
    push(4'd4, 1'b0, STEP_DIV);
    push(4'd5, 1'b0, STEP_DIV);
    push(4'd5, 1'b0, STEP_DIV);
    push(4'd5, 1'b0, STEP_DIV);
    push(4'd4, 1'b0, STEP_DIV);
    push(4'd3, 1'b0, STEP_DIV);
    push(4'd2, 1'b0, STEP_DIV);
    push(4'd2, 1'b0, STEP_DIV);
    push(4'd2, 1'b1, STEP_DIV);
    push(4'd3, 1'b0, STEP_DIV);
    push(4'd4, 1'b0, STEP_DIV);
    drain();

    // drop EN just before a step edge: that step must be suppressed
    repeat (STEP_DIV - 1 - LAT) @(negedge clk);
    #1 fade.en = 1'b0;
    @(posedge clk);
    #1;
    repeat (LAT) begin
      @(posedge clk);
      #1;
    end
    chk("en_drop_intensity", int'(fade.intensity), 0);
    chk("en_drop_tick", int'(fade.step_tick), 0);
    repeat (6) @(negedge clk);

    #1 fade.en = 1'b1;
    start_edge();
    chk("reenable_level", int'(fade.intensity), int'(exp_i(4'd2)));
    push(4'd3, 1'b0, STEP_DIV + LAT);
    push(4'd4, 1'b0, STEP_DIV);
    drain();

    // peak lowered below current level mid-ramp
    fade.max_level = 4'd3;
    push(4'd3, 1'b0, STEP_DIV);
    push(4'd3, 1'b0, STEP_DIV);
    push(4'd3, 1'b0, STEP_DIV);
    push(4'd2, 1'b0, STEP_DIV);
    push(4'd2, 1'b0, STEP_DIV);
    push(4'd2, 1'b1, STEP_DIV);
    drain();
    fade.max_level = 4'd5;
    push(4'd3, 1'b0, STEP_DIV);
    push(4'd4, 1'b0, STEP_DIV);
    drain();

    // asynchronous reset between edges, then restart
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_intensity", int'(fade.intensity), 0);
    chk("midrst_tick", int'(fade.step_tick), 0);
    chk("midrst_done", int'(fade.cycle_done), 0);
    #1 rst_n = 1'b1;
    start_edge();
    chk("post_rst_level", int'(fade.intensity), int'(exp_i(4'd2)));
    push(4'd3, 1'b0, STEP_DIV + LAT);
    push(4'd4, 1'b0, STEP_DIV);
    drain();

    // degenerate range: constant level, ticks continue, never a cycle_done
    fade.min_level = 4'd7;
    fade.max_level = 4'd7;
    for (int i = 0; i < 100; i++) push(4'd7, 1'b0, STEP_DIV);
    drain();

    // full-scale ramp 0..15
    fade.en = 1'b0;
    repeat (1 + LAT) @(posedge clk);
    @(negedge clk);
    #1;
    fade.min_level = 4'd0;
    fade.max_level = 4'd15;
    fade.en        = 1'b1;
    start_edge();
    chk("full_start", int'(fade.intensity), int'(exp_i(4'd0)));
    for (int i = 1; i <= 15; i++) push(4'(i), 1'b0, (i == 1) ? STEP_DIV + LAT : STEP_DIV);
    push(4'd15, 1'b0, STEP_DIV);
    push(4'd15, 1'b0, STEP_DIV);
    push(4'd14, 1'b0, STEP_DIV);
    drain();

    fade.en = 1'b0;
    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
